// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: shares dmem between the CPU load/store port and a
// debug burst port. The CPU normally wins; a starvation counter forces one
// debug slot (and one CPU stall cycle) after MAX_WAIT consecutive CPU wins.
//
// Handshake: a debug burst is accepted when dbg_start=1 is sampled in IDLE
// with dbg_len!=0. Each debug grant consumes one word: on a write burst
// dbg_wready=1 marks the cycle dbg_wdata is taken (the word must be held
// until then); on a read burst dbg_rvalid=1 qualifies dbg_rdata one cycle
// after the grant. dbg_done pulses for one cycle after the last word.
module dmem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_mem_read,
  input  logic              cpu_mem_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_start,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_base,
  input  logic [LEN_W-1:0]  dbg_len,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_wready,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic              dbg_busy,
  output logic              dbg_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

  state_t             state_q;
  state_t             state_d;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   rem_q;
  logic [WAIT_W-1:0]  wait_cnt;

  logic               cpu_req;
  logic               in_burst;
  logic               wait_at_max;
  logic               last_word;
  logic               start_burst;
  logic               start_empty;
  logic               dbg_grant;

  // Word alignment drops the low base bits on purpose.
  logic               base_lo_unused;
  assign base_lo_unused = ^dbg_base[1:0];

  // Arbitration terms shared by the FSM, outputs and datapath.
  always_comb begin
    cpu_req     = cpu_mem_read | cpu_mem_write;
    in_burst    = (state_q == S_BURST);
    wait_at_max = (wait_cnt == WAIT_W'(MAX_WAIT));
    last_word   = (rem_q == LEN_W'(1));
    start_burst = (state_q == S_IDLE) && dbg_start && (dbg_len != '0);
    start_empty = (state_q == S_IDLE) && dbg_start && (dbg_len == '0);
    // Reset takes the slot away from debug so the CPU path drives dmem.
    dbg_grant   = in_burst && !reset && (!cpu_req || wait_at_max);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: leave IDLE on an accepted burst, return after the last grant.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_burst)            state_d = S_BURST;
      S_BURST: if (dbg_grant && last_word) state_d = S_IDLE;
      default:                             state_d = S_IDLE;
    endcase
  end

  // FSM outputs: memory mux, stall and write-handshake, all combinational.
  always_comb begin
    cpu_rdata  = mem_rdata;
    dbg_busy   = in_burst;
    cpu_stall  = in_burst && !reset && cpu_req && wait_at_max;
    dbg_wready = dbg_grant && we_q;
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_wdata;
    mem_we     = 1'b0;
    if (dbg_grant) begin
      mem_addr  = addr_q;
      mem_wdata = dbg_wdata;
      mem_we    = we_q;
    end else if (!reset) begin
      mem_we    = cpu_mem_write;
    end
  end

  // Burst datapath: latch the request, advance per grant, count CPU wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q       <= 1'b0;
      addr_q     <= '0;
      rem_q      <= '0;
      wait_cnt   <= '0;
      dbg_rdata  <= '0;
      dbg_rvalid <= 1'b0;
      dbg_done   <= 1'b0;
    end else begin
      dbg_done   <= start_empty || (dbg_grant && last_word);
      dbg_rvalid <= dbg_grant && !we_q;
      if (dbg_grant && !we_q) begin
        dbg_rdata <= mem_rdata;
      end
      if (state_q == S_IDLE) begin
        wait_cnt <= '0;
        if (start_burst) begin
          we_q   <= dbg_we;
          addr_q <= {dbg_base[ADDR_W-1:2], 2'b00};
          rem_q  <= dbg_len;
        end
      end else if (dbg_grant) begin
        addr_q   <= addr_q + ADDR_W'(4);
        rem_q    <= rem_q - LEN_W'(1);
        wait_cnt <= '0;
      end else if (cpu_req) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end

endmodule
